// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared state encodings, exception codes and vector offsets
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } seq_state_e;

  // Bit positions inside the {fiq, irq, dabt, pabt, swi, undef} request vector
  localparam int EXC_BIT_UNDEF = 0;
  localparam int EXC_BIT_SWI   = 1;
  localparam int EXC_BIT_PABT  = 2;
  localparam int EXC_BIT_DABT  = 3;
  localparam int EXC_BIT_IRQ   = 4;
  localparam int EXC_BIT_FIQ   = 5;

  localparam logic [2:0] EXC_UNDEF = 3'd0;
  localparam logic [2:0] EXC_SWI   = 3'd1;
  localparam logic [2:0] EXC_PABT  = 3'd2;
  localparam logic [2:0] EXC_DABT  = 3'd3;
  localparam logic [2:0] EXC_IRQ   = 3'd5;
  localparam logic [2:0] EXC_FIQ   = 3'd6;

  localparam logic [4:0] OFF_UNDEF = 5'h04;
  localparam logic [4:0] OFF_SWI   = 5'h08;
  localparam logic [4:0] OFF_PABT  = 5'h0C;
  localparam logic [4:0] OFF_DABT  = 5'h10;
  localparam logic [4:0] OFF_IRQ   = 5'h18;
  localparam logic [4:0] OFF_FIQ   = 5'h1C;

  // Redirect ranking used when merging pending events; 0 means nothing
  localparam logic [2:0] RANK_NONE   = 3'd0;
  localparam logic [2:0] RANK_BRANCH = 3'd1;

  function automatic logic [2:0] exc_rank(input logic [2:0] code);
    logic [2:0] r;
    r = RANK_NONE;
    case (code)
      EXC_DABT:  r = 3'd7;
      EXC_FIQ:   r = 3'd6;
      EXC_IRQ:   r = 3'd5;
      EXC_PABT:  r = 3'd4;
      EXC_UNDEF: r = 3'd3;
      EXC_SWI:   r = 3'd2;
      default:   r = RANK_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - combinational exception priority encoder
module exc_prio_enc
  import pipeline_pkg::*;
(
  input  logic [5:0] i_exc,
  output logic       o_valid,
  output logic [2:0] o_code,
  output logic [4:0] o_offset
);

  always_comb begin
    o_valid  = 1'b1;
    o_code   = EXC_UNDEF;
    o_offset = OFF_UNDEF;
    if (i_exc[EXC_BIT_DABT]) begin
      o_code   = EXC_DABT;
      o_offset = OFF_DABT;
    end else if (i_exc[EXC_BIT_FIQ]) begin
      o_code   = EXC_FIQ;
      o_offset = OFF_FIQ;
    end else if (i_exc[EXC_BIT_IRQ]) begin
      o_code   = EXC_IRQ;
      o_offset = OFF_IRQ;
    end else if (i_exc[EXC_BIT_PABT]) begin
      o_code   = EXC_PABT;
      o_offset = OFF_PABT;
    end else if (i_exc[EXC_BIT_UNDEF]) begin
      o_code   = EXC_UNDEF;
      o_offset = OFF_UNDEF;
    end else if (i_exc[EXC_BIT_SWI]) begin
      o_code   = EXC_SWI;
      o_offset = OFF_SWI;
    end else begin
      o_valid  = 1'b0;
      o_code   = EXC_UNDEF;
      o_offset = 5'h00;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with branch/exception redirect and pending latch
module pc_sequencer
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] VEC_BASE     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic [5:0]            i_exc,
  input  logic [DATA_WIDTH-1:0] i_exc_pc,
  input  logic                  i_imem_ack,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_PC,
  output logic                  o_inst_valid,
  output logic                  o_exc_taken,
  output logic [2:0]            o_exc_code,
  output logic [DATA_WIDTH-1:0] o_link_pc
);

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_is_exc_q, pend_is_exc_d;
  logic [2:0]            pend_code_q, pend_code_d;
  logic [DATA_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [DATA_WIDTH-1:0] pend_link_q, pend_link_d;
  logic                  exc_taken_q, exc_taken_d;
  logic [2:0]            exc_code_q, exc_code_d;
  logic [DATA_WIDTH-1:0] link_q, link_d;

  logic                  enc_valid;
  logic [2:0]            enc_code;
  logic [4:0]            enc_offset;

  logic                  req_active;
  logic                  ack_hit;
  logic                  cur_valid;
  logic [2:0]            cur_rank;
  logic [2:0]            pend_rank;
  logic [DATA_WIDTH-1:0] cur_target;
  logic                  mrg_valid;
  logic                  mrg_is_exc;
  logic [2:0]            mrg_code;
  logic [DATA_WIDTH-1:0] mrg_target;
  logic [DATA_WIDTH-1:0] mrg_link;

  exc_prio_enc u_exc_prio_enc (
    .i_exc    (i_exc),
    .o_valid  (enc_valid),
    .o_code   (enc_code),
    .o_offset (enc_offset)
  );

  // Merge this cycle's strobe with the latched event; a tie keeps the older one
  always_comb begin
    req_active = (state_q == S_WAIT) || ((state_q == S_REQ) && !i_stall);
    ack_hit    = req_active && i_imem_ack;
    cur_valid  = enc_valid || i_branch;
    cur_rank   = enc_valid ? exc_rank(enc_code) : (i_branch ? RANK_BRANCH : RANK_NONE);
    cur_target = enc_valid ? (VEC_BASE + DATA_WIDTH'(enc_offset)) : i_branch_target;
    pend_rank  = !pend_valid_q ? RANK_NONE
               : (pend_is_exc_q ? exc_rank(pend_code_q) : RANK_BRANCH);
    mrg_valid  = pend_valid_q || cur_valid;
    if (cur_rank > pend_rank) begin
      mrg_is_exc = enc_valid;
      mrg_code   = enc_code;
      mrg_target = cur_target;
      mrg_link   = i_exc_pc;
    end else begin
      mrg_is_exc = pend_is_exc_q;
      mrg_code   = pend_code_q;
      mrg_target = pend_target_q;
      mrg_link   = pend_link_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_is_exc_d = pend_is_exc_q;
    pend_code_d   = pend_code_q;
    pend_target_d = pend_target_q;
    pend_link_d   = pend_link_q;
    exc_taken_d   = 1'b0;
    exc_code_d    = exc_code_q;
    link_d        = link_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        pc_d    = RESET_VECTOR;
      end
      S_REQ, S_WAIT: begin
        if (ack_hit) begin
          state_d      = S_REQ;
          pend_valid_d = 1'b0;
          if (mrg_valid) begin
            pc_d = mrg_target;
            if (mrg_is_exc) begin
              exc_taken_d = 1'b1;
              exc_code_d  = mrg_code;
              link_d      = mrg_link;
            end
          end else begin
            pc_d = pc_q + DATA_WIDTH'(4);
          end
        end else begin
          if (req_active) begin
            state_d = S_WAIT;
          end
          pend_valid_d  = mrg_valid;
          pend_is_exc_d = mrg_is_exc;
          pend_code_d   = mrg_code;
          pend_target_d = mrg_target;
          pend_link_d   = mrg_link;
        end
      end
      S_HALT: begin
        if (i_exc[EXC_BIT_FIQ] || i_exc[EXC_BIT_IRQ]) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_is_exc_q <= 1'b0;
      pend_code_q   <= 3'd0;
      pend_target_q <= '0;
      pend_link_q   <= '0;
      exc_taken_q   <= 1'b0;
      exc_code_q    <= 3'd0;
      link_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_is_exc_q <= pend_is_exc_d;
      pend_code_q   <= pend_code_d;
      pend_target_q <= pend_target_d;
      pend_link_q   <= pend_link_d;
      exc_taken_q   <= exc_taken_d;
      exc_code_q    <= exc_code_d;
      link_q        <= link_d;
    end
  end

  assign o_imem_req   = req_active;
  assign o_inst_valid = ack_hit && !mrg_valid;
  assign o_PC         = pc_q;
  assign o_exc_taken  = exc_taken_q;
  assign o_exc_code   = exc_code_q;
  assign o_link_pc    = link_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized bench for pc_sequencer against a behavioural fetch model
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] VB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_stall, i_branch, i_imem_ack;
  logic [31:0] i_branch_target, i_exc_pc;
  logic [5:0]  i_exc;
  logic        o_imem_req, o_inst_valid, o_exc_taken;
  logic [31:0] o_PC, o_link_pc;
  logic [2:0]  o_exc_code;

  int n_vec = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  pc_sequencer #(.DATA_WIDTH(32), .RESET_VECTOR(RV), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_branch(i_branch),
    .i_branch_target(i_branch_target), .i_exc(i_exc), .i_exc_pc(i_exc_pc),
    .i_imem_ack(i_imem_ack), .o_imem_req(o_imem_req), .o_PC(o_PC),
    .o_inst_valid(o_inst_valid), .o_exc_taken(o_exc_taken),
    .o_exc_code(o_exc_code), .o_link_pc(o_link_pc)
  );

  always #5 clk = ~clk;

  // Exception table in priority order: request bit, code, vector offset
  int unsigned ebit [6] = '{3, 5, 4, 2, 0, 1};
  logic [2:0]  ecode[6] = '{3'd3, 3'd6, 3'd5, 3'd2, 3'd0, 3'd1};
  logic [31:0] eoff [6] = '{32'h10, 32'h1C, 32'h18, 32'h0C, 32'h04, 32'h08};

  typedef struct {
    bit          valid;
    bit          is_exc;
    int          prio;
    logic [31:0] target;
    logic [31:0] link;
    logic [2:0]  code;
  } ev_t;

  function automatic ev_t no_event();
    ev_t e;
    e.valid = 0; e.is_exc = 0; e.prio = 0; e.target = 0; e.link = 0; e.code = 0;
    return e;
  endfunction

  function automatic ev_t incoming();
    ev_t e;
    e = no_event();
    for (int k = 0; k < 6; k++) begin
      if (!e.valid && i_exc[ebit[k]]) begin
        e.valid = 1; e.is_exc = 1; e.prio = 10 - k;
        e.target = VB + eoff[k]; e.link = i_exc_pc; e.code = ecode[k];
      end
    end
    if (!e.valid && i_branch) begin
      e.valid = 1; e.prio = 1; e.target = i_branch_target;
    end
    return e;
  endfunction

  bit          m_boot = 1;
  bit          m_out = 0;
  ev_t         m_pend = '{0, 0, 0, 32'h0, 32'h0, 3'h0};
  logic [31:0] m_pc = RV;
  logic [31:0] m_link = 0;
  logic [2:0]  m_code = 0;
  bit          m_taken = 0;

  always @(posedge clk or negedge reset) begin : model
    ev_t cur, sel;
    bit  req;
    if (!reset) begin
      m_boot = 1; m_out = 0; m_pend = no_event(); m_pc = RV;
      m_link = 0; m_code = 0; m_taken = 0;
    end else if (m_boot) begin
      m_boot = 0; m_taken = 0;
    end else begin
      req = m_out || !i_stall;
      cur = incoming();
      sel = (cur.prio > m_pend.prio) ? cur : m_pend;
      m_taken = 0;
      if (req && i_imem_ack) begin
        if (sel.valid) begin
          m_pc = sel.target;
          if (sel.is_exc) begin
            m_taken = 1; m_code = sel.code; m_link = sel.link;
          end
        end else begin
          m_pc = m_pc + 32'd4;
        end
        m_pend = no_event();
        m_out = 0;
      end else begin
        m_pend = sel;
        if (req) m_out = 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    ev_t cur;
    bit  er, ev;
    if (check_en) begin
      cur = incoming();
      er  = reset && !m_boot && (m_out || !i_stall);
      ev  = er && i_imem_ack && !m_pend.valid && !cur.valid;
      check("m_pc", o_PC, m_pc);
      check("m_req", 32'(o_imem_req), 32'(er));
      check("m_valid", 32'(o_inst_valid), 32'(ev));
      check("m_taken", 32'(o_exc_taken), 32'(m_taken));
      check("m_code", 32'(o_exc_code), 32'(m_code));
      check("m_link", o_link_pc, m_link);
    end
  end

  task automatic set_in(input bit st, input bit br, input logic [31:0] tg,
                        input logic [5:0] ex, input logic [31:0] epc, input bit ak);
    i_stall = st; i_branch = br; i_branch_target = tg;
    i_exc = ex; i_exc_pc = epc; i_imem_ack = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    check_en = 1'b1;
    tick(); tick();
    #1;
    check("rst_pc", o_PC, RV);
    check("rst_req", 32'(o_imem_req), 0);
    check("rst_valid", 32'(o_inst_valid), 0);
    check("rst_taken", 32'(o_exc_taken), 0);
    check("rst_code", 32'(o_exc_code), 0);
    check("rst_link", o_link_pc, 0);

    @(posedge clk); #1;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    check("boot_req", 32'(o_imem_req), 0);
    check("boot_valid", 32'(o_inst_valid), 0);
    tick();
    check("seq_pc0", o_PC, 32'h0);
    #1 check("seq_valid0", 32'(o_inst_valid), 1);
    tick(); check("seq_pc4", o_PC, 32'h4);
    tick(); check("seq_pc8", o_PC, 32'h8);
    tick(); check("seq_pcC", o_PC, 32'hC);

    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("wait_req", 32'(o_imem_req), 1);
      tick();
      check("wait_pc", o_PC, 32'hC);
    end
    set_in(0, 0, 0, 0, 0, 1);
    #1 check("wait_ack_valid", 32'(o_inst_valid), 1);
    tick(); check("wait_adv", o_PC, 32'h10);

    set_in(0, 1, 32'h1000_0000, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("br_hold", o_PC, 32'h10);
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    #1 check("br_kill", 32'(o_inst_valid), 0);
    tick(); check("br_pc", o_PC, 32'h1000_0000);

    set_in(0, 0, 0, 6'b011000, 32'h20, 1);
    #1 check("exc_kill", 32'(o_inst_valid), 0);
    tick();
    check("exc_pc", o_PC, 32'h10);
    check("exc_code", 32'(o_exc_code), 3);
    check("exc_link", o_link_pc, 32'h20);
    check("exc_taken", 32'(o_exc_taken), 1);
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    check("exc_pulse_end", 32'(o_exc_taken), 0);
    check("exc_next", o_PC, 32'h14);

    set_in(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    tick(); check("wrap_top", o_PC, 32'hFFFF_FFFC);
    set_in(0, 0, 0, 0, 0, 1);
    tick(); check("wrap_zero", o_PC, 32'h0);

    for (int i = 0; i < 4; i++) begin
      set_in(1, i == 1, 32'h200, 0, 0, 1);
      #1 check("stall_req", 32'(o_imem_req), 0);
      tick();
      check("stall_pc", o_PC, 32'h0);
    end
    set_in(0, 0, 0, 0, 0, 1);
    #1 check("stall_pend_kill", 32'(o_inst_valid), 0);
    tick(); check("stall_pend_pc", o_PC, 32'h200);

    set_in(0, 1, 32'h300, 0, 0, 0); tick();
    set_in(0, 1, 32'h400, 0, 0, 0); tick();
    set_in(0, 0, 0, 6'b000010, 32'h55, 0); tick();
    set_in(0, 0, 0, 6'b000001, 32'h66, 0); tick();
    set_in(0, 0, 0, 0, 0, 1); tick();
    check("ovr_pc", o_PC, 32'h4);
    check("ovr_code", 32'(o_exc_code), 0);
    check("ovr_link", o_link_pc, 32'h66);

    set_in(0, 1, 32'h300, 0, 0, 0); tick();
    set_in(0, 1, 32'h400, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1); tick();
    check("eq_keep_first", o_PC, 32'h300);

    set_in(0, 0, 0, 0, 0, 0); tick();
    check("ar_wait_pc", o_PC, 32'h300);
    #2 reset = 1'b0;
    #1;
    check("ar_pc", o_PC, RV);
    check("ar_req", 32'(o_imem_req), 0);
    tick();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 1);
    #1 check("ar_boot_valid", 32'(o_inst_valid), 0);
    tick(); check("ar_boot_pc", o_PC, RV);
    tick(); check("ar_first_adv", o_PC, RV + 32'd4);

    for (int i = 0; i < 4000; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 10) == 0, $urandom & 32'hFFFF_FFFC,
             (($urandom % 12) == 0) ? 6'($urandom % 64) : 6'd0, $urandom, $urandom % 2);
      if ((i % 997) == 996) begin
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
